ghost_sprite_renderer: RTL and testbench
========================================

// Module: ghost_sprite_renderer
// PURPOSE
//  Pixel-pipeline stage downstream of the 15x15 ghost sprite ROM (2-bit colour index, 1-cycle
//  registered read). Takes the VGA beam position and the ghost position and generates the ROM
//  read address. It then aligns the returned index with the beam and maps it to 24-bit RGB plus a
//  pixel_on flag for the colour mapper. It also owns the ghost's frightened/flashing mode timer.
// PARAMETERS
//  SPRITE_W      15   sprite width/height in pixels (ROM holds SPRITE_W*SPRITE_W entries)
//  BODY_RGB      24'hFF0000  normal body colour (per ghost instance)
//  FRIGHT_FRAMES 360  frames spent frightened (FRIGHT + FLASH) per frightened_start
//  FLASH_FRAMES  120  final frames of the frightened period spent flashing
//  BLINK_FRAMES  15   frames per flash half-period
// PORTS
//  Clk              in   1   pixel clock
//  Reset            in   1   asynchronous, active-high reset
//  frame_tick       in   1   1-cycle pulse once per frame (start of vblank)
//  frightened_start in   1   1-cycle pulse: enter/restart frightened mode
//  DrawX, DrawY     in   10  current beam pixel
//  GhostX, GhostY   in   10  sprite top-left pixel
//  dir_left         in   1   ghost facing left (used only with GHOST_MIRROR_EN)
//  rom_addr         out  8   read address to sprite ROM
//  rom_data         in   2   colour index from sprite ROM (valid 1 cycle after rom_addr)
//  pixel_on         out  1   ghost covers this pixel (non-transparent)
//  Red, Green, Blue out  8   pixel colour; 0 when pixel_on=0
//  frightened       out  1   state is FRIGHT or FLASH
// BEHAVIOUR
//  Reset: rom_addr=0, pixel_on=0, RGB=0, frightened=0, state NORMAL, frame_cnt=0, blink=0.
//  Hit test, 11-bit math, no wrap: dx=DrawX-GhostX, dy=DrawY-GhostY.
//    inbox = DrawX>=GhostX && DrawX<GhostX+SPRITE_W && same for Y.
//  Addr: dy*SPRITE_W+dx (max 224); rom_addr forced 0 when !inbox.
//  Pipeline: cycle N sample beam; N+1 rom_addr + inbox_d1 + mode_d1 registered.
//    N+2 rom_data valid, inbox_d2/mode_d2 registered.
//    N+3 pixel_on/RGB registered. Fixed latency 3; one pixel per clock, no stalls.
//  Palette (at N+3, using mode_d2):
//    idx0: transparent, pixel_on=0, RGB=0.
//    idx1 body: NORMAL BODY_RGB; FRIGHT 24'h2121DE; FLASH blink?24'hFFFFFF:24'h2121DE.
//    idx2 eyes: NORMAL 24'hFFFFFF; FRIGHT/FLASH 24'hFFB8AE.
//    idx3 pupils: NORMAL 24'h2121DE; FRIGHT/FLASH 24'hFFB8AE.
//    pixel_on=inbox_d2 && idx!=0.
//  Mode FSM, updates only on Clk; frame_cnt counts frames:
//    NORMAL: frightened_start -> FRIGHT, frame_cnt=FRIGHT_FRAMES, blink=0.
//    FRIGHT: frame_tick decrements frame_cnt. Reaching FLASH_FRAMES -> FLASH, blink=1, blink_cnt=0.
//    FLASH: frame_tick decrements frame_cnt and advances blink_cnt.
//      blink_cnt reaching BLINK_FRAMES-1 -> toggle blink, blink_cnt=0.
//      frame_cnt reaching 0 -> NORMAL, blink=0.
//    frightened_start in any state reloads frame_cnt=FRIGHT_FRAMES and enters FRIGHT.
//    start + frame_tick same cycle: start wins, no decrement.
//    Mode changes mid-frame take effect on pixels sampled after the change (mode travels in pipeline).
//  Reset mid-frame: pipeline cleared; the first 3 output pixels after release are off.
// CONFIGURATION
//  GHOST_MIRROR_EN defined: when dir_left=1, column uses (SPRITE_W-1-dx): addr=dy*SPRITE_W+(SPRITE_W-1-dx).
//    Latched per pixel at cycle N.
//  GHOST_MIRROR_EN undefined: dir_left ignored; addr=dy*SPRITE_W+dx always.
// TESTING
//  1 Ghost(100,50), beam (100,50)->(114,50): rom_addr 0..14 at N+1; pixel_on/RGB track ROM idx at N+3.
//  2 Beam (99,50), (115,50), (100,65): rom_addr=0, pixel_on=0 three cycles later.
//    GhostX=1015 with DrawX=5: no false hit.
//  3 ROM idx1 under NORMAL -> RGB FF0000.
//    Pulse frightened_start -> frightened=1, idx1 -> 2121DE.
//    After 240 frame_ticks: FLASH, blink=1, body FFFFFF; body alternates every 15 frames.
//    After 360 total: NORMAL.
//  4 frightened_start in FLASH with frame_tick same cycle: state FRIGHT, frame_cnt=360.
//  5 Assert Reset mid-line and mid-frightened: all outputs 0 immediately (async), state NORMAL.
//  6 GHOST_MIRROR_EN, dir_left=1, beam (100,50): rom_addr=14. Undefined: rom_addr=0.

Source files
------------

// File: rtl/ghost_sprite_renderer.sv
// Ghost sprite pixel stage: ROM addressing, 3-cycle aligned palette lookup, frightened/flash mode timer.
// Optional horizontal mirroring for left-facing ghosts when GHOST_MIRROR_EN is defined.
module ghost_sprite_renderer #(
    parameter int          SPRITE_W      = 15,
    parameter logic [23:0] BODY_RGB      = 24'hFF0000,
    parameter int          FRIGHT_FRAMES = 360,
    parameter int          FLASH_FRAMES  = 120,
    parameter int          BLINK_FRAMES  = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       frightened_start,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] GhostX,
    input  logic [9:0] GhostY,
    input  logic       dir_left,
    output logic [7:0] rom_addr,
    input  logic [1:0] rom_data,
    output logic       pixel_on,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
    output logic       frightened
);

    typedef enum logic [1:0] {S_NORMAL, S_FRIGHT, S_FLASH} state_t;

    localparam int CW = $clog2(FRIGHT_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    localparam logic [23:0] C_BLUE  = 24'h2121DE;
    localparam logic [23:0] C_WHITE = 24'hFFFFFF;
    localparam logic [23:0] C_PALE  = 24'hFFB8AE;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_frame_cnt, w_frame_cnt_nx;
    logic [BW-1:0]   r_blink_cnt, w_blink_cnt_nx;
    logic            r_blink, w_blink_nx;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_NORMAL;
            r_frame_cnt <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_frame_cnt <= w_frame_cnt_nx;
            r_blink_cnt <= w_blink_cnt_nx;
            r_blink     <= w_blink_nx;
        end
    end

    // A start pulse overrides any same-cycle frame_tick: reload without decrement.
    always_comb begin
        w_state_nx     = r_state;
        w_frame_cnt_nx = r_frame_cnt;
        w_blink_cnt_nx = r_blink_cnt;
        w_blink_nx     = r_blink;
        if (frightened_start) begin
            w_state_nx     = S_FRIGHT;
            w_frame_cnt_nx = CW'(FRIGHT_FRAMES);
            w_blink_cnt_nx = '0;
            w_blink_nx     = 1'b0;
        end else if (frame_tick) begin
            case (r_state)
                S_FRIGHT: begin
                    w_frame_cnt_nx = r_frame_cnt - 1'b1;
                    if (r_frame_cnt == CW'(FLASH_FRAMES + 1)) begin
                        w_state_nx     = S_FLASH;
                        w_blink_nx     = 1'b1;
                        w_blink_cnt_nx = '0;
                    end
                end
                S_FLASH: begin
                    w_frame_cnt_nx = r_frame_cnt - 1'b1;
                    if (r_frame_cnt == CW'(1)) begin
                        w_state_nx = S_NORMAL;
                        w_blink_nx = 1'b0;
                    end else if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                        w_blink_nx     = ~r_blink;
                        w_blink_cnt_nx = '0;
                    end else begin
                        w_blink_cnt_nx = r_blink_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign frightened = (r_state != S_NORMAL);

    logic [10:0] w_dx, w_dy;
    logic        w_inbox;
    logic [7:0]  w_col, w_addr;
    logic        w_unused;

    assign w_dx    = {1'b0, DrawX} - {1'b0, GhostX};
    assign w_dy    = {1'b0, DrawY} - {1'b0, GhostY};
    assign w_inbox = (DrawX >= GhostX) && ({1'b0, DrawX} < ({1'b0, GhostX} + 11'(SPRITE_W))) &&
                     (DrawY >= GhostY) && ({1'b0, DrawY} < ({1'b0, GhostY} + 11'(SPRITE_W)));

`ifdef GHOST_MIRROR_EN
    assign w_col    = dir_left ? (8'(SPRITE_W - 1) - w_dx[7:0]) : w_dx[7:0];
    assign w_unused = ^{w_dx[10:8], w_dy[10:8]};
`else
    assign w_col    = w_dx[7:0];
    assign w_unused = ^{w_dx[10:8], w_dy[10:8], dir_left};
`endif

    assign w_addr = w_dy[7:0] * 8'(SPRITE_W) + w_col;

    // Mode rides alongside the pixel so mid-frame changes affect only later samples.
    logic [7:0]  r_rom_addr;
    logic        r_inbox_d1, r_inbox_d2;
    logic [2:0]  r_mode_d1, r_mode_d2;
    logic        r_pix_on;
    logic [23:0] r_rgb, w_pal;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rom_addr <= '0;
            r_inbox_d1 <= 1'b0;
            r_inbox_d2 <= 1'b0;
            r_mode_d1  <= '0;
            r_mode_d2  <= '0;
            r_pix_on   <= 1'b0;
            r_rgb      <= '0;
        end else begin
            r_rom_addr <= w_inbox ? w_addr : 8'd0;
            r_inbox_d1 <= w_inbox;
            r_mode_d1  <= {r_state, r_blink};
            r_inbox_d2 <= r_inbox_d1;
            r_mode_d2  <= r_mode_d1;
            r_pix_on   <= r_inbox_d2 && (rom_data != 2'd0);
            r_rgb      <= r_inbox_d2 ? w_pal : 24'd0;
        end
    end

    state_t w_m_state;
    logic   w_m_blink;
    assign w_m_state = state_t'(r_mode_d2[2:1]);
    assign w_m_blink = r_mode_d2[0];

    always_comb begin
        w_pal = 24'd0;
        case (rom_data)
            2'd1: begin
                case (w_m_state)
                    S_FRIGHT: w_pal = C_BLUE;
                    S_FLASH:  w_pal = w_m_blink ? C_WHITE : C_BLUE;
                    default:  w_pal = BODY_RGB;
                endcase
            end
            2'd2:    w_pal = (w_m_state == S_NORMAL) ? C_WHITE : C_PALE;
            2'd3:    w_pal = (w_m_state == S_NORMAL) ? C_BLUE  : C_PALE;
            default: w_pal = 24'd0;
        endcase
    end

    assign rom_addr = r_rom_addr;
    assign pixel_on = r_pix_on;
    assign Red      = r_rgb[23:16];
    assign Green    = r_rgb[15:8];
    assign Blue     = r_rgb[7:0];

endmodule

// File: tb/tb_ghost_sprite_renderer.sv
// Directed bench for ghost_sprite_renderer; local ROM model returns idx = (addr+1) mod 4.
module tb_ghost_sprite_renderer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       frightened_start = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0, GhostX = '0, GhostY = '0;
    logic       dir_left = 1'b0;
    logic [7:0] rom_addr;
    logic [1:0] rom_data = '0;
    logic       pixel_on;
    logic [7:0] Red, Green, Blue;
    logic       frightened;

    int checks = 0;
    int errors = 0;

    ghost_sprite_renderer dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .frightened_start(frightened_start),
        .DrawX(DrawX), .DrawY(DrawY), .GhostX(GhostX), .GhostY(GhostY), .dir_left(dir_left),
        .rom_addr(rom_addr), .rom_data(rom_data), .pixel_on(pixel_on),
        .Red(Red), .Green(Green), .Blue(Blue), .frightened(frightened)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom_addr[1:0] + 2'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) cyc();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
    endtask

    function automatic logic [23:0] normal_rgb(input int idx);
        case (idx)
            1:       return 24'hFF0000;
            2:       return 24'hFFFFFF;
            3:       return 24'h2121DE;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic miss(input string tag, input logic [9:0] x, input logic [9:0] y,
                        input logic [9:0] gx, input logic [9:0] gy);
        DrawX = x; DrawY = y; GhostX = gx; GhostY = gy;
        cyc();
        chk({tag, "_addr"}, 32'(rom_addr), 32'd0);
        cyc(); cyc();
        chk({tag, "_on"}, 32'(pixel_on), 32'd0);
        chk({tag, "_rgb"}, {8'd0, Red, Green, Blue}, 32'd0);
    endtask

    initial begin
        GhostX = 10'd100; GhostY = 10'd50; DrawX = 10'd100; DrawY = 10'd50;
        #1;
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_on", 32'(pixel_on), 32'd0);
        chk("rst_rgb", {8'd0, Red, Green, Blue}, 32'd0);
        chk("rst_fr", 32'(frightened), 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk) Reset = 1'b0;
        cyc();

        // Row scan across the sprite, then two pixels past its right edge
        for (int c = 0; c < 17; c++) begin
            DrawX = 10'(100 + c);
            cyc();
            chk($sformatf("scan_addr%0d", c), 32'(rom_addr), (c < 15) ? 32'(c) : 32'd0);
            if (c >= 2) begin
                int p, idx;
                p   = c - 2;
                idx = (p + 1) % 4;
                chk($sformatf("scan_on%0d", p), 32'(pixel_on), (idx != 0) ? 32'd1 : 32'd0);
                chk($sformatf("scan_rgb%0d", p), {8'd0, Red, Green, Blue}, {8'd0, normal_rgb(idx)});
            end
        end

        miss("left", 10'd99, 10'd50, 10'd100, 10'd50);
        miss("right", 10'd115, 10'd50, 10'd100, 10'd50);
        miss("below", 10'd100, 10'd65, 10'd100, 10'd50);
        miss("wrap", 10'd5, 10'd50, 10'd1015, 10'd50);
        GhostX = 10'd100; GhostY = 10'd50;

        // Frightened lifecycle on a body pixel (addr 0 -> idx 1)
        DrawX = 10'd100; DrawY = 10'd50;
        settle();
        chk("norm_body", {8'd0, Red, Green, Blue}, 32'hFF0000);
        frightened_start = 1'b1; cyc(); frightened_start = 1'b0;
        chk("fr_flag", 32'(frightened), 32'd1);
        settle();
        chk("fr_body", {8'd0, Red, Green, Blue}, 32'h2121DE);
        DrawX = 10'd101; settle();
        chk("fr_eyes", {8'd0, Red, Green, Blue}, 32'hFFB8AE);
        DrawX = 10'd100;
        ticks(239); settle();
        chk("fr_239", {8'd0, Red, Green, Blue}, 32'h2121DE);
        ticks(1); settle();
        chk("flash_on", {8'd0, Red, Green, Blue}, 32'hFFFFFF);
        ticks(14); settle();
        chk("blink_hold", {8'd0, Red, Green, Blue}, 32'hFFFFFF);
        ticks(1); settle();
        chk("blink_tog", {8'd0, Red, Green, Blue}, 32'h2121DE);
        ticks(104); settle();
        chk("fr_359", 32'(frightened), 32'd1);
        ticks(1); settle();
        chk("fr_done", 32'(frightened), 32'd0);
        chk("back_norm", {8'd0, Red, Green, Blue}, 32'hFF0000);

        // Restart from FLASH with a coincident tick: full reload, no decrement
        frightened_start = 1'b1; cyc(); frightened_start = 1'b0;
        ticks(240); settle();
        chk("r_flash", {8'd0, Red, Green, Blue}, 32'hFFFFFF);
        frightened_start = 1'b1; frame_tick = 1'b1; cyc();
        frightened_start = 1'b0; frame_tick = 1'b0;
        settle();
        chk("r_fright", {8'd0, Red, Green, Blue}, 32'h2121DE);
        ticks(239); settle();
        chk("r_239", {8'd0, Red, Green, Blue}, 32'h2121DE);
        ticks(1); settle();
        chk("r_240", {8'd0, Red, Green, Blue}, 32'hFFFFFF);

        // Asynchronous reset mid-line while flashing
        DrawX = 10'd101; cyc();
        chk("pre_rst_addr", 32'(rom_addr), 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("arst_addr", 32'(rom_addr), 32'd0);
        chk("arst_on", 32'(pixel_on), 32'd0);
        chk("arst_rgb", {8'd0, Red, Green, Blue}, 32'd0);
        chk("arst_fr", 32'(frightened), 32'd0);
        DrawX = 10'd100;
        @(negedge Clk) Reset = 1'b0;
        cyc();
        chk("rel_on1", 32'(pixel_on), 32'd0);
        cyc();
        chk("rel_on2", 32'(pixel_on), 32'd0);
        cyc();
        chk("rel_on3", 32'(pixel_on), 32'd1);
        chk("rel_rgb3", {8'd0, Red, Green, Blue}, 32'hFF0000);

        // Facing left at the sprite's first column
        dir_left = 1'b1; DrawX = 10'd100; DrawY = 10'd50;
        cyc();
`ifdef GHOST_MIRROR_EN
        chk("mirror", 32'(rom_addr), 32'd14);
`else
        chk("mirror", 32'(rom_addr), 32'd0);
`endif
        dir_left = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
